rst_sequencer: RTL and testbench

RST_SEQUENCER -- requirements
Module: rst_sequencer

---
 rtl/rst_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_rst_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronizes reset release and PLL lock, then releases
// NUM_CH active-low reset channels one by one with a fixed spacing.
module rst_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_CH      = 4,
    parameter int LOCK_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int SW_HOLD     = 16
) (
    input  logic              clk_riscv,
    input  logic              reset,
    input  logic              pll_locked,
    input  logic              sw_rst_req,
    output logic [NUM_CH-1:0] rst_n_out,
    output logic              busy,
    output logic [1:0]        rst_cause
);

    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int GAP_W  = $clog2(STAGE_GAP + 1);
    localparam int HOLD_W = $clog2(SW_HOLD + 1);
    localparam int CH_W   = $clog2(NUM_CH + 1);

    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SW_HOLD - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);

    localparam logic [1:0] CAUSE_EXT  = 2'd0;
    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_SW   = 2'd2;

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        SW_RST    = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] rel_sync_r;
    logic [SYNC_STAGES-1:0] lock_sync_r;
    logic                   rel_s;
    logic                   lock_s;

    state_t              state_r,    state_s;
    logic [LOCK_W-1:0]   lock_cnt_r, lock_cnt_s;
    logic [GAP_W-1:0]    gap_cnt_r,  gap_cnt_s;
    logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_s;
    logic [CH_W-1:0]     ch_idx_r,   ch_idx_s;
    logic [NUM_CH-1:0]   rst_n_r,    rst_n_s;
    logic [1:0]          cause_r,    cause_s;
    logic                busy_r;

    // Reset-release and lock synchronizers, both cleared by the async reset.
    always_ff @(posedge clk_riscv or posedge reset) begin
        if (reset) begin
            rel_sync_r  <= '0;
            lock_sync_r <= '0;
        end else begin
            rel_sync_r  <= {rel_sync_r[SYNC_STAGES-2:0], 1'b1};
            lock_sync_r <= {lock_sync_r[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign rel_s  = rel_sync_r[SYNC_STAGES-1];
    assign lock_s = lock_sync_r[SYNC_STAGES-1];

    // Next-state, counter and output computation for the sequencer FSM.
    always_comb begin
        state_s    = state_r;
        lock_cnt_s = lock_cnt_r;
        gap_cnt_s  = gap_cnt_r;
        hold_cnt_s = hold_cnt_r;
        ch_idx_s   = ch_idx_r;
        rst_n_s    = rst_n_r;
        cause_s    = cause_r;

        case (state_r)
            HOLD: begin
                rst_n_s = '0;
                if (rel_s) begin
                    state_s    = WAIT_LOCK;
                    lock_cnt_s = '0;
                end else begin
                    state_s = HOLD;
                end
            end

            WAIT_LOCK: begin
                rst_n_s = '0;
                if (lock_s) begin
                    if (lock_cnt_r == LOCK_LAST) begin
                        state_s    = RELEASE;
                        lock_cnt_s = '0;
                        gap_cnt_s  = '0;
                        ch_idx_s   = '0;
                    end else begin
                        lock_cnt_s = lock_cnt_r + LOCK_W'(1);
                    end
                end else begin
                    lock_cnt_s = '0;
                end
            end

            RELEASE: begin
                if (!lock_s) begin
                    state_s    = WAIT_LOCK;
                    rst_n_s    = '0;
                    cause_s    = CAUSE_LOCK;
                    lock_cnt_s = '0;
                end else if (gap_cnt_r == GAP_LAST) begin
                    rst_n_s   = rst_n_r | (NUM_CH'(1'b1) << ch_idx_r);
                    gap_cnt_s = '0;
                    if (ch_idx_r == CH_LAST) begin
                        state_s  = RUN;
                        ch_idx_s = '0;
                    end else begin
                        ch_idx_s = ch_idx_r + CH_W'(1);
                    end
                end else begin
                    gap_cnt_s = gap_cnt_r + GAP_W'(1);
                end
            end

            RUN: begin
                // Lock loss takes priority over a simultaneous software request.
                if (!lock_s) begin
                    state_s    = WAIT_LOCK;
                    rst_n_s    = '0;
                    cause_s    = CAUSE_LOCK;
                    lock_cnt_s = '0;
                end else if (sw_rst_req) begin
                    state_s    = SW_RST;
                    rst_n_s    = '0;
                    cause_s    = CAUSE_SW;
                    hold_cnt_s = '0;
                end else begin
                    state_s = RUN;
                end
            end

            SW_RST: begin
                rst_n_s = '0;
                if (!lock_s) begin
                    state_s    = WAIT_LOCK;
                    cause_s    = CAUSE_LOCK;
                    lock_cnt_s = '0;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    state_s    = RELEASE;
                    hold_cnt_s = '0;
                    gap_cnt_s  = '0;
                    ch_idx_s   = '0;
                end else begin
                    hold_cnt_s = hold_cnt_r + HOLD_W'(1);
                end
            end

            default: begin
                state_s    = HOLD;
                rst_n_s    = '0;
                lock_cnt_s = '0;
                gap_cnt_s  = '0;
                hold_cnt_s = '0;
                ch_idx_s   = '0;
                cause_s    = CAUSE_EXT;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk_riscv or posedge reset) begin
        if (reset) begin
            state_r    <= HOLD;
            lock_cnt_r <= '0;
            gap_cnt_r  <= '0;
            hold_cnt_r <= '0;
            ch_idx_r   <= '0;
            rst_n_r    <= '0;
            cause_r    <= CAUSE_EXT;
            busy_r     <= 1'b1;
        end else begin
            state_r    <= state_s;
            lock_cnt_r <= lock_cnt_s;
            gap_cnt_r  <= gap_cnt_s;
            hold_cnt_r <= hold_cnt_s;
            ch_idx_r   <= ch_idx_s;
            rst_n_r    <= rst_n_s;
            cause_r    <= cause_s;
            busy_r     <= (state_s != RUN);
        end
    end

    assign rst_n_out = rst_n_r;
    assign busy      = busy_r;
    assign rst_cause = cause_r;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer (SYNC_STAGES=2, NUM_CH=3, LOCK_CYCLES=4,
// STAGE_GAP=2, SW_HOLD=5) with a queue of expected output snapshots.
module tb_rst_sequencer;

    logic       clk_riscv;
    logic       reset;
    logic       pll_locked;
    logic       sw_rst_req;
    logic [2:0] rst_n_out;
    logic       busy;
    logic [1:0] rst_cause;

    int tests_run;
    int tests_failed;

    string      tag_q[$];
    logic [5:0] exp_q[$];

    rst_sequencer #(
        .SYNC_STAGES(2),
        .NUM_CH     (3),
        .LOCK_CYCLES(4),
        .STAGE_GAP  (2),
        .SW_HOLD    (5)
    ) dut (
        .clk_riscv (clk_riscv),
        .reset     (reset),
        .pll_locked(pll_locked),
        .sw_rst_req(sw_rst_req),
        .rst_n_out (rst_n_out),
        .busy      (busy),
        .rst_cause (rst_cause)
    );

    initial clk_riscv = 1'b0;
    always #5 clk_riscv = ~clk_riscv;

    task automatic push_exp(input string tag, input logic [2:0] r,
                            input logic b, input logic [1:0] c);
        tag_q.push_back(tag);
        exp_q.push_back({r, b, c});
    endtask

    task automatic pop_check();
        string      tag;
        logic [5:0] exp_v;
        logic [5:0] obs_v;
        tag   = tag_q.pop_front();
        exp_v = exp_q.pop_front();
        obs_v = {rst_n_out, busy, rst_cause};
        tests_run++;
        assert (obs_v === exp_v) else begin
            tests_failed++;
            $error("FAIL %s: observed rst_n/busy/cause=%b_%b_%b expected %b_%b_%b",
                   tag, obs_v[5:3], obs_v[2], obs_v[1:0],
                   exp_v[5:3], exp_v[2], exp_v[1:0]);
        end
    endtask

    // n clock edges, outputs checked at the falling edge after each one
    task automatic hold(input int n, input string tag, input logic [2:0] r,
                        input logic b, input logic [1:0] c);
        for (int i = 0; i < n; i++) begin
            push_exp(tag, r, b, c);
            @(posedge clk_riscv);
            @(negedge clk_riscv);
            pop_check();
        end
    endtask

    // Full release after lock_s first reads high two edges after relock
    task automatic reseq(input string tag, input logic [1:0] c);
        hold(7, {tag, "_wait"}, 3'b000, 1'b1, c);
        hold(2, {tag, "_ch0"},  3'b001, 1'b1, c);
        hold(2, {tag, "_ch1"},  3'b011, 1'b1, c);
        hold(1, {tag, "_ch2"},  3'b111, 1'b0, c);
        hold(2, {tag, "_run"},  3'b111, 1'b0, c);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        pll_locked   = 1'b1;
        sw_rst_req   = 1'b0;

        #1;
        push_exp("reset_state", 3'b000, 1'b1, 2'd0);
        pop_check();

        repeat (5) @(negedge clk_riscv);
        hold(0, "none", 3'b000, 1'b1, 2'd0);
        reset = 1'b0;
        hold(8, "pwr_wait", 3'b000, 1'b1, 2'd0);
        hold(2, "pwr_ch0",  3'b001, 1'b1, 2'd0);
        hold(2, "pwr_ch1",  3'b011, 1'b1, 2'd0);
        hold(1, "pwr_ch2",  3'b111, 1'b0, 2'd0);
        hold(2, "pwr_run",  3'b111, 1'b0, 2'd0);

        // Re-reset from RUN, then a one-cycle lock glitch in WAIT_LOCK
        reset = 1'b1;
        #1;
        push_exp("reset_in_run", 3'b000, 1'b1, 2'd0);
        pop_check();
        repeat (2) @(negedge clk_riscv);
        reset = 1'b0;
        hold(4, "glitch_pre",  3'b000, 1'b1, 2'd0);
        pll_locked = 1'b0;
        hold(1, "glitch_low",  3'b000, 1'b1, 2'd0);
        pll_locked = 1'b1;
        hold(7, "glitch_wait", 3'b000, 1'b1, 2'd0);
        hold(2, "glitch_ch0",  3'b001, 1'b1, 2'd0);
        hold(2, "glitch_ch1",  3'b011, 1'b1, 2'd0);
        hold(1, "glitch_ch2",  3'b111, 1'b0, 2'd0);
        hold(2, "glitch_run",  3'b111, 1'b0, 2'd0);

        // Lock loss in RUN
        pll_locked = 1'b0;
        hold(2, "loss_sync", 3'b111, 1'b0, 2'd0);
        hold(1, "loss_drop", 3'b000, 1'b1, 2'd1);
        hold(2, "loss_low",  3'b000, 1'b1, 2'd1);
        pll_locked = 1'b1;
        reseq("relock", 2'd1);

        // Software reset, plus a request during RELEASE that must be ignored
        sw_rst_req = 1'b1;
        hold(1, "sw_drop", 3'b000, 1'b1, 2'd2);
        sw_rst_req = 1'b0;
        hold(6, "sw_hold", 3'b000, 1'b1, 2'd2);
        hold(1, "sw_ch0",  3'b001, 1'b1, 2'd2);
        sw_rst_req = 1'b1;
        hold(1, "sw_ignored", 3'b001, 1'b1, 2'd2);
        sw_rst_req = 1'b0;
        hold(2, "sw_ch1",  3'b011, 1'b1, 2'd2);
        hold(1, "sw_ch2",  3'b111, 1'b0, 2'd2);
        hold(2, "sw_run",  3'b111, 1'b0, 2'd2);

        // Lock loss and software request seen on the same edge
        pll_locked = 1'b0;
        hold(2, "both_sync", 3'b111, 1'b0, 2'd2);
        sw_rst_req = 1'b1;
        hold(1, "both_drop", 3'b000, 1'b1, 2'd1);
        sw_rst_req = 1'b0;
        hold(2, "both_low",  3'b000, 1'b1, 2'd1);
        pll_locked = 1'b1;
        reseq("both_relock", 2'd1);

        // Lock loss again, then async reset with 011 mid-release
        pll_locked = 1'b0;
        hold(2, "mid_sync", 3'b111, 1'b0, 2'd1);
        hold(1, "mid_drop", 3'b000, 1'b1, 2'd1);
        pll_locked = 1'b1;
        hold(7, "mid_wait", 3'b000, 1'b1, 2'd1);
        hold(2, "mid_ch0",  3'b001, 1'b1, 2'd1);
        hold(1, "mid_ch1",  3'b011, 1'b1, 2'd1);
        reset = 1'b1;
        #1;
        push_exp("async_reset", 3'b000, 1'b1, 2'd0);
        pop_check();
        hold(2, "reset_held", 3'b000, 1'b1, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
